// File: rtl/mag_sequencer_if.sv
// Start/valid handshake between the magnitude sequencer (master) and a shared
// iterative square-root unit (slave).
interface mag_sequencer_if #(
    parameter int RW = 25
);
    logic          sqrt_start;
    logic [RW-1:0] sqrt_rad;
    logic          sqrt_busy;
    logic          sqrt_valid;
    logic [RW-1:0] sqrt_root;

    // sqrt_start is a one-cycle pulse; sqrt_rad holds until sqrt_valid or
    // abandonment; sqrt_valid is a one-cycle strobe qualifying sqrt_root.
    modport master (
        output sqrt_start,
        output sqrt_rad,
        input  sqrt_busy,
        input  sqrt_valid,
        input  sqrt_root
    );

    modport slave (
        input  sqrt_start,
        input  sqrt_rad,
        output sqrt_busy,
        output sqrt_valid,
        output sqrt_root
    );
endinterface

// File: rtl/mag_sequencer.sv
// Sequences one shared integer square-root unit over the complex bins of a frame,
// producing sqrt(re^2 + im^2) per bin and publishing the whole vector at once.
module mag_sequencer #(
    parameter int N_BINS  = 8,
    parameter int DW      = 12,
    parameter int RW      = 25,
    parameter int MW      = 13,
    parameter int TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   frame_valid,
    input  logic [N_BINS*DW-1:0]   frame_re,
    input  logic [N_BINS*DW-1:0]   frame_im,
    mag_sequencer_if.master        sqrt,
    output logic [N_BINS*MW-1:0]   mag,
    output logic                   mag_valid,
    output logic                   busy,
    output logic [7:0]             overrun_cnt,
    output logic                   timeout_err,
    output logic [2:0]             dbg_state
);
    localparam int IW = (N_BINS > 1) ? $clog2(N_BINS) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CALC  = 3'd1,
        S_START = 3'd2,
        S_WAIT  = 3'd3,
        S_NEXT  = 3'd4
    } state_t;

    state_t                  state_q;
    logic signed [DW-1:0]    work_re_q [N_BINS];
    logic signed [DW-1:0]    work_im_q [N_BINS];
    logic signed [DW-1:0]    pend_re_q [N_BINS];
    logic signed [DW-1:0]    pend_im_q [N_BINS];
    logic [MW-1:0]           shadow_q  [N_BINS];
    logic                    pend_full_q;
    logic [IW-1:0]           idx_q;
    logic [TW-1:0]           timer_q;
    logic [RW-1:0]           rad_q;
    logic                    start_q;
    logic [N_BINS*MW-1:0]    mag_q;
    logic                    mag_valid_q;
    logic [7:0]              overrun_q;
    logic                    timeout_err_q;

    logic signed [DW-1:0]    in_re [N_BINS];
    logic signed [DW-1:0]    in_im [N_BINS];
    logic signed [2*DW-1:0]  cur_re_x;
    logic signed [2*DW-1:0]  cur_im_x;
    logic signed [2*DW-1:0]  sq_re;
    logic signed [2*DW-1:0]  sq_im;
    logic [RW-1:0]           rad_d;
    logic                    unused_root;

    always_comb begin
        for (int k = 0; k < N_BINS; k++) begin
            in_re[k] = frame_re[k*DW +: DW];
            in_im[k] = frame_im[k*DW +: DW];
        end
    end

    // Squares are non-negative, so zero-extending them to RW cannot lose sign.
    assign cur_re_x = {{DW{work_re_q[idx_q][DW-1]}}, work_re_q[idx_q]};
    assign cur_im_x = {{DW{work_im_q[idx_q][DW-1]}}, work_im_q[idx_q]};
    assign sq_re    = cur_re_x * cur_re_x;
    assign sq_im    = cur_im_x * cur_im_x;
    assign rad_d    = {{(RW-2*DW){1'b0}}, sq_re} + {{(RW-2*DW){1'b0}}, sq_im};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            pend_full_q   <= 1'b0;
            idx_q         <= '0;
            timer_q       <= '0;
            rad_q         <= '0;
            start_q       <= 1'b0;
            mag_q         <= '0;
            mag_valid_q   <= 1'b0;
            overrun_q     <= '0;
            timeout_err_q <= 1'b0;
            for (int k = 0; k < N_BINS; k++) begin
                work_re_q[k] <= '0;
                work_im_q[k] <= '0;
                pend_re_q[k] <= '0;
                pend_im_q[k] <= '0;
                shadow_q[k]  <= '0;
            end
        end else begin
            start_q     <= 1'b0;
            mag_valid_q <= 1'b0;

            if (frame_valid && state_q != S_IDLE) begin
                pend_re_q   <= in_re;
                pend_im_q   <= in_im;
                pend_full_q <= 1'b1;
                if (pend_full_q && overrun_q != 8'hFF) begin
                    overrun_q <= overrun_q + 8'd1;
                end
            end

            case (state_q)
                S_IDLE: begin
                    if (pend_full_q) begin
                        work_re_q <= pend_re_q;
                        work_im_q <= pend_im_q;
                        state_q   <= S_CALC;
                        // A frame arriving while the pending one drains refills the slot.
                        if (frame_valid) begin
                            pend_re_q <= in_re;
                            pend_im_q <= in_im;
                        end else begin
                            pend_full_q <= 1'b0;
                        end
                    end else if (frame_valid) begin
                        work_re_q <= in_re;
                        work_im_q <= in_im;
                        state_q   <= S_CALC;
                    end
                end
                S_CALC: begin
                    rad_q   <= rad_d;
                    state_q <= S_START;
                end
                S_START: begin
                    if (!sqrt.sqrt_busy) begin
                        start_q <= 1'b1;
                        timer_q <= '0;
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    timer_q <= timer_q + TW'(1);
                    if (sqrt.sqrt_valid) begin
                        shadow_q[idx_q] <= sqrt.sqrt_root[MW-1:0];
                        state_q         <= S_NEXT;
                    end else if (timer_q == TW'(TIMEOUT - 1)) begin
                        shadow_q[idx_q] <= '0;
                        timeout_err_q   <= 1'b1;
                        state_q         <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    if (idx_q == IW'(N_BINS - 1)) begin
                        for (int k = 0; k < N_BINS; k++) begin
                            mag_q[k*MW +: MW] <= shadow_q[k];
                        end
                        mag_valid_q <= 1'b1;
                        idx_q       <= '0;
                        state_q     <= S_IDLE;
                    end else begin
                        idx_q   <= idx_q + IW'(1);
                        state_q <= S_CALC;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign unused_root     = ^sqrt.sqrt_root[RW-1:MW];
    assign sqrt.sqrt_start = start_q;
    assign sqrt.sqrt_rad   = rad_q;
    assign mag             = mag_q;
    assign mag_valid       = mag_valid_q;
    assign busy            = (state_q != S_IDLE);
    assign overrun_cnt     = overrun_q;
    assign timeout_err     = timeout_err_q;
    assign dbg_state       = state_q;
endmodule

// File: tb/tb_mag_sequencer.sv
// Directed bench for mag_sequencer with a behavioural sqrt unit of fixed latency.
module tb_mag_sequencer;
    localparam int N_BINS  = 8;
    localparam int DW      = 12;
    localparam int RW      = 25;
    localparam int MW      = 13;
    localparam int TIMEOUT = 64;
    localparam int LAT     = 13;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  reset;
    logic                  frame_valid;
    logic [N_BINS*DW-1:0]  frame_re;
    logic [N_BINS*DW-1:0]  frame_im;
    logic [N_BINS*MW-1:0]  mag;
    logic                  mag_valid;
    logic                  busy;
    logic [7:0]            overrun_cnt;
    logic                  timeout_err;
    logic [2:0]            dbg_state;

    mag_sequencer_if #(.RW(RW)) sif ();

    mag_sequencer #(
        .N_BINS(N_BINS), .DW(DW), .RW(RW), .MW(MW), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .frame_valid(frame_valid),
        .frame_re(frame_re), .frame_im(frame_im), .sqrt(sif.master),
        .mag(mag), .mag_valid(mag_valid), .busy(busy),
        .overrun_cnt(overrun_cnt), .timeout_err(timeout_err), .dbg_state(dbg_state)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- sqrt unit model ----------------
    logic          m_busy = 1'b0;
    logic          force_busy = 1'b0;
    int            m_cnt = 0;
    int            start_n = 0;
    int            hang_bin = -1;
    logic [RW-1:0] m_rad = '0;
    logic [RW-1:0] rad_at_valid = '0;
    logic [RW-1:0] rad_log[$];

    assign sif.sqrt_busy = m_busy | force_busy;

    function automatic logic [RW-1:0] isqrt(input logic [RW-1:0] x);
        longint unsigned r = 0;
        while ((r + 1) * (r + 1) <= longint'(x)) r++;
        return RW'(r);
    endfunction

    initial begin
        sif.sqrt_valid = 1'b0;
        sif.sqrt_root  = '0;
        forever begin
            @(negedge clk);
            sif.sqrt_valid = 1'b0;
            if (reset) begin
                m_cnt  = 0;
                m_busy = 1'b0;
            end else begin
                if (m_cnt > 0) begin
                    m_cnt--;
                    if (m_cnt == 0) begin
                        sif.sqrt_valid = 1'b1;
                        sif.sqrt_root  = isqrt(m_rad);
                        rad_at_valid   = sif.sqrt_rad;
                        m_busy         = 1'b0;
                    end
                end
                if (sif.sqrt_start) begin
                    m_rad = sif.sqrt_rad;
                    rad_log.push_back(m_rad);
                    if (start_n != hang_bin) begin
                        m_cnt  = LAT;
                        m_busy = 1'b1;
                    end
                    start_n++;
                end
            end
        end
    end

    // ---------------- mag_valid monitor ----------------
    int                   mv_cnt = 0;
    logic [N_BINS*MW-1:0] mag_log[$];

    initial begin
        forever begin
            @(negedge clk);
            if (mag_valid) begin
                mv_cnt++;
                mag_log.push_back(mag);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_frame(input logic [N_BINS*DW-1:0] re, input logic [N_BINS*DW-1:0] im);
        @(negedge clk);
        frame_re    = re;
        frame_im    = im;
        frame_valid = 1'b1;
        @(negedge clk);
        frame_valid = 1'b0;
    endtask

    task automatic wait_mv(input int target, input string tag);
        int c = 0;
        while (mv_cnt < target && c < 3000) begin
            @(negedge clk);
            c++;
        end
        if (mv_cnt < target) check({tag, "_mv_timeout"}, 128'(mv_cnt), 128'(target));
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [N_BINS*MW-1:0] log_at(input int i);
        if (i < mag_log.size()) return mag_log[i];
        return '1;
    endfunction

    // ---------------- stimulus ----------------
    logic [N_BINS*DW-1:0] re_v, im_v, re_t1, im_t1;
    logic [N_BINS*MW-1:0] exp_mag, exp_t1;
    int base, s0, c;

    initial begin
        reset = 1'b1; frame_valid = 1'b0; frame_re = '0; frame_im = '0;
        idle(3);
        check("rst_mag", 128'(mag), 128'(0));
        check("rst_mag_valid", 128'(mag_valid), 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_overrun", 128'(overrun_cnt), 128'(0));
        check("rst_timeout", 128'(timeout_err), 128'(0));
        check("rst_start", 128'(sif.sqrt_start), 128'(0));
        check("rst_rad", 128'(sif.sqrt_rad), 128'(0));
        reset = 1'b0;
        idle(2);

        // Bin0 (3,4) -> 5, bin1 (-5,12) -> 13.
        re_t1 = '0; im_t1 = '0;
        re_t1[0*DW +: DW] = 12'sd3;  im_t1[0*DW +: DW] = 12'sd4;
        re_t1[1*DW +: DW] = -12'sd5; im_t1[1*DW +: DW] = 12'sd12;
        exp_t1 = '0;
        exp_t1[0*MW +: MW] = 13'd5;
        exp_t1[1*MW +: MW] = 13'd13;
        base = mv_cnt;
        send_frame(re_t1, im_t1);
        wait_mv(base + 1, "t1");
        @(negedge clk);
        check("t1_busy_after", 128'(busy), 128'(0));
        idle(20);
        check("t1_mv_count", 128'(mv_cnt - base), 128'(1));
        check("t1_mag", 128'(log_at(base)), 128'(exp_t1));
        check("t1_mag_held", 128'(mag), 128'(exp_t1));

        // Most negative components everywhere.
        re_v = '0; im_v = '0; exp_mag = '0;
        for (int k = 0; k < N_BINS; k++) begin
            re_v[k*DW +: DW]    = 12'h800;
            im_v[k*DW +: DW]    = 12'h800;
            exp_mag[k*MW +: MW] = 13'd2896;
        end
        rad_log.delete();
        base = mv_cnt;
        send_frame(re_v, im_v);
        wait_mv(base + 1, "t2");
        check("t2_mag", 128'(log_at(base)), 128'(exp_mag));
        check("t2_start_count", 128'(rad_log.size()), 128'(N_BINS));
        for (int k = 0; k < N_BINS; k++) begin
            if (k < rad_log.size()) check($sformatf("t2_rad%0d", k), 128'(rad_log[k]), 128'(8388608));
        end
        check("t2_overrun", 128'(overrun_cnt), 128'(0));
        check("t2_timeout", 128'(timeout_err), 128'(0));

        // Three frames two cycles apart: the middle one is overwritten.
        base = mv_cnt;
        re_v = '0; im_v = '0;
        re_v[0*DW +: DW] = 12'sd6; im_v[0*DW +: DW] = 12'sd8;
        send_frame(re_v, im_v);
        re_v = '0; im_v = '0;
        re_v[0*DW +: DW] = 12'sd1;
        send_frame(re_v, im_v);
        re_v = '0; im_v = '0;
        im_v[0*DW +: DW] = 12'sd7;
        re_v[7*DW +: DW] = -12'sd9; im_v[7*DW +: DW] = -12'sd12;
        send_frame(re_v, im_v);
        wait_mv(base + 2, "t3");
        idle(30);
        check("t3_mv_count", 128'(mv_cnt - base), 128'(2));
        exp_mag = '0; exp_mag[0*MW +: MW] = 13'd10;
        check("t3_mag_f1", 128'(log_at(base)), 128'(exp_mag));
        exp_mag = '0; exp_mag[0*MW +: MW] = 13'd7; exp_mag[7*MW +: MW] = 13'd15;
        check("t3_mag_f3", 128'(log_at(base + 1)), 128'(exp_mag));
        check("t3_overrun", 128'(overrun_cnt), 128'(1));

        // sqrt unit reports busy for 10 cycles at the first START.
        re_v = '0; im_v = '0;
        re_v[0*DW +: DW] = 12'sd8; im_v[0*DW +: DW] = 12'sd15;
        force_busy = 1'b1;
        s0 = start_n;
        base = mv_cnt;
        send_frame(re_v, im_v);
        idle(10);
        check("t4_no_start_while_busy", 128'(start_n - s0), 128'(0));
        check("t4_state_start", 128'(dbg_state), 128'(2));
        force_busy = 1'b0;
        c = 0;
        while (!sif.sqrt_start && c < 10) begin
            @(negedge clk);
            c++;
        end
        check("t4_start_seen", 128'(sif.sqrt_start), 128'(1));
        check("t4_rad", 128'(sif.sqrt_rad), 128'(289));
        @(negedge clk);
        check("t4_start_width", 128'(sif.sqrt_start), 128'(0));
        idle(LAT + 2);
        check("t4_rad_stable", 128'(rad_at_valid), 128'(289));
        wait_mv(base + 1, "t4");
        exp_mag = '0; exp_mag[0*MW +: MW] = 13'd17;
        check("t4_mag", 128'(log_at(base)), 128'(exp_mag));

        // Bin 2 never gets a result.
        re_v = '0; im_v = '0; exp_mag = '0;
        for (int k = 0; k < N_BINS; k++) begin
            re_v[k*DW +: DW]    = DW'(k + 1);
            exp_mag[k*MW +: MW] = (k == 2) ? 13'd0 : MW'(k + 1);
        end
        start_n  = 0;
        hang_bin = 2;
        base = mv_cnt;
        send_frame(re_v, im_v);
        wait_mv(base + 1, "t5");
        hang_bin = -1;
        idle(20);
        check("t5_mv_count", 128'(mv_cnt - base), 128'(1));
        check("t5_mag", 128'(log_at(base)), 128'(exp_mag));
        check("t5_timeout", 128'(timeout_err), 128'(1));

        // Reset while waiting on bin 4.
        start_n = 0;
        send_frame(re_t1, im_t1);
        c = 0;
        while (start_n < 5 && c < 500) begin
            @(negedge clk);
            c++;
        end
        check("t6_reached_bin4", 128'(start_n), 128'(5));
        idle(3);
        check("t6_in_wait", 128'(dbg_state), 128'(3));
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("t6_busy", 128'(busy), 128'(0));
        check("t6_mag", 128'(mag), 128'(0));
        check("t6_mag_valid", 128'(mag_valid), 128'(0));
        check("t6_overrun", 128'(overrun_cnt), 128'(0));
        check("t6_timeout", 128'(timeout_err), 128'(0));
        idle(2);
        base = mv_cnt;
        send_frame(re_t1, im_t1);
        wait_mv(base + 1, "t6");
        idle(20);
        check("t6_mv_count", 128'(mv_cnt - base), 128'(1));
        check("t6_mag_after", 128'(log_at(base)), 128'(exp_t1));
        check("t6_timeout_after", 128'(timeout_err), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/mag_sequencer.md
Name: mag_sequencer

Overview:
- Sequences one shared iterative integer square-root unit across the N_BINS complex FFT outputs of a frame.
- Produces one magnitude per bin, sqrt(re^2 + im^2), and presents the whole vector with a one-cycle done strobe.
- Sits between the FFT source-side result capture and the display/peak logic.
- Owns the sqrt start/valid handshake, buffers one pending frame, and recovers from a hung sqrt unit via timeout.

Parameters:
- N_BINS, 8, number of complex bins per frame.
- DW, 12, width of each signed real/imag component.
- RW, 25, sqrt radicand width; must be >= 2*DW+1.
- MW, 13, magnitude width; low MW bits of sqrt_root.
- TIMEOUT, 64, max cycles from sqrt_start to sqrt_valid before the bin is abandoned.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- frame_valid  in  1  one-cycle strobe: frame_re/frame_im hold a complete frame.
- frame_re  in  N_BINS*DW  signed real parts; bin k at [k*DW +: DW].
- frame_im  in  N_BINS*DW  signed imag parts; same packing.
- sqrt_start  out  1  one-cycle start pulse to the sqrt unit.
- sqrt_rad  out  RW  radicand; stable from the start pulse until valid or timeout.
- sqrt_busy  in  1  sqrt unit computing.
- sqrt_valid  in  1  one-cycle result strobe.
- sqrt_root  in  RW  sqrt result.
- mag  out  N_BINS*MW  magnitudes; bin k at [k*MW +: MW].
- mag_valid  out  1  one-cycle strobe: mag updated with a complete frame.
- busy  out  1  high whenever state != IDLE.
- overrun_cnt  out  8  saturating count of frames discarded.
- timeout_err  out  1  sticky; set on any sqrt timeout.

Behaviour:
- Reset (synchronous, clk edge with reset=1): all outputs 0, state IDLE, pending buffer empty, bin index 0, timer 0. Reset mid-frame abandons the frame; mag is cleared.
- Frame capture:
  - frame_valid in IDLE: copy frame into the working buffer; next state CALC.
  - frame_valid while busy: copy into the one-deep pending buffer and set pend_full.
  - If pend_full was already set, the new frame overwrites the pending frame and overrun_cnt increments, saturating at 255.
- States:
  - IDLE: if pend_full, move pending to working, clear pend_full, go to CALC. Otherwise wait for frame_valid.
  - CALC: register sqrt_rad = re[idx]^2 + im[idx]^2. Squares are signed multiplies, zero-extended to RW; the sum never overflows (max 2^(2DW-1), e.g. -2048^2*2 = 8388608). Go to START.
  - START: wait until sqrt_busy=0, then assert sqrt_start for exactly one cycle, clear the timer, go to WAIT.
  - WAIT: increment the timer each cycle.
    - On sqrt_valid: latch sqrt_root[MW-1:0] into a shadow mag[idx]; go to NEXT.
    - If the timer reaches TIMEOUT before sqrt_valid: shadow mag[idx] = 0, set timeout_err, go to NEXT. A later stray sqrt_valid is ignored outside WAIT.
  - NEXT: if idx == N_BINS-1, copy the shadow to mag, pulse mag_valid for 1 cycle, reset idx to 0, go to IDLE. Else increment idx, go to CALC.
- mag changes only on the mag_valid cycle; consumers never see a partially updated frame.
- Latency, frame_valid to mag_valid: N_BINS*(4 + L), plus 1 cycle for the IDLE transition, where L is the sqrt start-to-valid latency. sqrt_busy high at START adds stall cycles.
- Simultaneous frame_valid in the same cycle as the NEXT→IDLE transition: the frame goes to pending, and IDLE consumes it on the next cycle (no loss, no overrun).
- sqrt_valid in the same cycle as the timer reaching TIMEOUT: treat as valid and store the root.

Test Plan:
- Frame with bin0 re=3 im=4, bin1 re=-5 im=12, rest 0; sqrt model L=13 → mag_valid once; mag bins 0,1 = 5, 13; others 0; busy falls the cycle after mag_valid.
- All bins re=-2048 im=-2048 → sqrt_rad=8388608 on each start; mag all 2896; overrun_cnt=0, timeout_err=0.
- Three frames strobed 2 cycles apart → frames 1 and 3 produce mag_valid; frame 2 discarded; overrun_cnt=1.
- Sqrt model never asserts valid for bin 2 → after 64 WAIT cycles mag bin2=0, timeout_err=1, remaining bins correct, one mag_valid.
- Hold sqrt_busy=1 for 10 cycles at START of bin 0 → sqrt_start deferred until busy drops; pulse width exactly 1 cycle; sqrt_rad stable through valid.
- Assert reset during WAIT of bin 4 → next cycle busy=0, mag=0, mag_valid=0, overrun_cnt=0, timeout_err=0; a new frame then completes normally.
